ldst_sequencer: RTL and testbench

LDST_SEQUENCER -- requirements
Module: ldst_sequencer

---
 rtl/ldst_sequencer_if.sv | 73 +++++++
 rtl/ldst_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_ldst_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ldst_sequencer_if.sv
// Handshake and control-strobe bundle between the load/store
// sequencer and the fetch/decode front end and datapath.
`timescale 1ns/1ps
interface ldst_sequencer_if;
  logic       start;
  logic [4:0] opcode;
  logic       mem_ready;

  logic Gra;
  logic Grb;
  logic Rin;
  logic Rout;
  logic BAout;
  logic Cout;
  logic Yin;
  logic Zin;
  logic Zlowout;
  logic MARin;
  logic MDRin;
  logic Read;
  logic Write;
  logic ADD;

  logic busy;
  logic done;
  logic error;

  modport master (
    output start,
    output opcode,
    output mem_ready,
    input  Gra,
    input  Grb,
    input  Rin,
    input  Rout,
    input  BAout,
    input  Cout,
    input  Yin,
    input  Zin,
    input  Zlowout,
    input  MARin,
    input  MDRin,
    input  Read,
    input  Write,
    input  ADD,
    input  busy,
    input  done,
    input  error
  );

  modport slave (
    input  start,
    input  opcode,
    input  mem_ready,
    output Gra,
    output Grb,
    output Rin,
    output Rout,
    output BAout,
    output Cout,
    output Yin,
    output Zin,
    output Zlowout,
    output MARin,
    output MDRin,
    output Read,
    output Write,
    output ADD,
    output busy,
    output done,
    output error
  );
endinterface

// File: rtl/ldst_sequencer.sv
// Moore control sequencer for ld / ldi / st, with a bounded
// memory wait and a one-cycle done or error pulse.
`timescale 1ns/1ps
module ldst_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input logic             clk,
  input logic             clr,
  ldst_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_T3   = 3'd1;
  localparam logic [2:0] S_T4   = 3'd2;
  localparam logic [2:0] S_T5   = 3'd3;
  localparam logic [2:0] S_T6   = 3'd4;
  localparam logic [2:0] S_T7   = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;
  localparam logic [2:0] S_ERR  = 3'd7;

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST  = 5'b00010;

  localparam logic [3:0] TMO = 4'(TIMEOUT);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [4:0] op;
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  logic       is_ld;
  logic       is_ldi;
  logic       is_st;
  logic       legal;
  logic       accept;
  logic       waiting;
  logic       expired;

  assign is_ld  = (op == OP_LD);
  assign is_ldi = (op == OP_LDI);
  assign is_st  = (op == OP_ST);

  assign legal = (bus.opcode == OP_LD)
              || (bus.opcode == OP_LDI)
              || (bus.opcode == OP_ST);

  assign accept = (state == S_IDLE) && bus.start;

  // ld waits in T6, st waits in T7
  assign waiting = ((state == S_T6) && is_ld)
                || ((state == S_T7) && is_st);

  assign cnt_inc = cnt + 4'd1;
  assign expired = !bus.mem_ready && (cnt_inc == TMO);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      op <= OP_LD;
    end else if (accept) begin
      op <= bus.opcode;
    end
  end

  // outside a wait state the counter sits at zero, so every
  // entry into a wait state starts from a fresh count
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt <= 4'd0;
    end else if (!waiting) begin
      cnt <= 4'd0;
    end else if (!bus.mem_ready) begin
      cnt <= cnt_inc;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = legal ? S_T3 : S_ERR;
        end
      end
      S_T3: state_nxt = S_T4;
      S_T4: state_nxt = S_T5;
      S_T5: state_nxt = is_ldi ? S_FIN : S_T6;
      S_T6: begin
        if (!is_ld) begin
          state_nxt = S_T7;
        end else if (bus.mem_ready) begin
          state_nxt = S_T7;
        end else if (expired) begin
          state_nxt = S_ERR;
        end
      end
      S_T7: begin
        if (!is_st) begin
          state_nxt = S_FIN;
        end else if (bus.mem_ready) begin
          state_nxt = S_FIN;
        end else if (expired) begin
          state_nxt = S_ERR;
        end
      end
      S_FIN:   state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.Gra     = 1'b0;
    bus.Grb     = 1'b0;
    bus.Rin     = 1'b0;
    bus.Rout    = 1'b0;
    bus.BAout   = 1'b0;
    bus.Cout    = 1'b0;
    bus.Yin     = 1'b0;
    bus.Zin     = 1'b0;
    bus.Zlowout = 1'b0;
    bus.MARin   = 1'b0;
    bus.MDRin   = 1'b0;
    bus.Read    = 1'b0;
    bus.Write   = 1'b0;
    bus.ADD     = 1'b0;
    bus.done    = 1'b0;
    bus.error   = 1'b0;
    case (state)
      S_T3: begin
        bus.Grb   = 1'b1;
        bus.BAout = 1'b1;
        bus.Rout  = 1'b1;
        bus.Yin   = 1'b1;
      end
      S_T4: begin
        bus.Cout = 1'b1;
        bus.ADD  = 1'b1;
        bus.Zin  = 1'b1;
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        if (is_ldi) begin
          bus.Gra = 1'b1;
          bus.Rin = 1'b1;
        end else begin
          bus.MARin = 1'b1;
        end
      end
      S_T6: begin
        unique case (1'b1)
          is_ld: begin
            bus.Read  = 1'b1;
            bus.MDRin = 1'b1;
          end
          is_st: begin
            bus.Gra   = 1'b1;
            bus.Rout  = 1'b1;
            bus.MDRin = 1'b1;
          end
          default: ;
        endcase
      end
      S_T7: begin
        unique case (1'b1)
          is_ld: begin
            bus.Gra = 1'b1;
            bus.Rin = 1'b1;
          end
          is_st: begin
            bus.Write = 1'b1;
          end
          default: ;
        endcase
      end
      S_FIN:   bus.done  = 1'b1;
      S_ERR:   bus.error = 1'b1;
      default: ;
    endcase
  end

  assign bus.busy = (state != S_IDLE);

endmodule

// File: tb/tb_ldst_sequencer.sv
// Self-checking bench for ldst_sequencer: scripted and random
// transactions compared cycle by cycle against expected traces.
`timescale 1ns/1ps
module tb_ldst_sequencer;

  localparam int T = 15;

  localparam logic [4:0] OP_LD  = 5'b00000;
  localparam logic [4:0] OP_LDI = 5'b00001;
  localparam logic [4:0] OP_ST  = 5'b00010;

  localparam logic [16:0] GRA   = 17'h00001;
  localparam logic [16:0] GRB   = 17'h00002;
  localparam logic [16:0] RIN   = 17'h00004;
  localparam logic [16:0] ROUT  = 17'h00008;
  localparam logic [16:0] BAOUT = 17'h00010;
  localparam logic [16:0] COUT  = 17'h00020;
  localparam logic [16:0] YIN   = 17'h00040;
  localparam logic [16:0] ZIN   = 17'h00080;
  localparam logic [16:0] ZLO   = 17'h00100;
  localparam logic [16:0] MARIN = 17'h00200;
  localparam logic [16:0] MDRIN = 17'h00400;
  localparam logic [16:0] READ  = 17'h00800;
  localparam logic [16:0] WRITE = 17'h01000;
  localparam logic [16:0] ADD   = 17'h02000;
  localparam logic [16:0] BUSY  = 17'h04000;
  localparam logic [16:0] DONE  = 17'h08000;
  localparam logic [16:0] ERR   = 17'h10000;

  typedef struct packed {
    logic        start;
    logic [4:0]  opc;
    logic        mr;
    logic [16:0] exp;
  } step_t;

  logic clk;
  logic clr;

  ldst_sequencer_if bus ();

  ldst_sequencer #(.TIMEOUT(T)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  step_t       scr[$];
  logic [16:0] exp_vec;
  bit          chk_en;

  wire [16:0] dv = {
    bus.error, bus.done, bus.busy, bus.ADD,
    bus.Write, bus.Read, bus.MDRin, bus.MARin,
    bus.Zlowout, bus.Zin, bus.Yin, bus.Cout,
    bus.BAout, bus.Rout, bus.Rin, bus.Grb, bus.Gra
  };

  // cycle-by-cycle comparison against the expected trace
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dv !== exp_vec) begin
        errors++;
        $display("FAIL trace @%0t: got %05h want %05h",
                 $time, dv, exp_vec);
      end
    end
  end

  // independent latency / strobe-count monitor
  int t, nrd, nwr, lat, lrd, lwr, ndone, nerr;
  bit run;
  initial begin
    t = 0; nrd = 0; nwr = 0; lat = 0; lrd = 0; lwr = 0;
    ndone = 0; nerr = 0; run = 0;
  end
  always @(negedge clk) begin
    if (clr) begin
      run = 0;
    end else begin
      if (run) begin
        t++;
        if (bus.Read)  nrd++;
        if (bus.Write) nwr++;
      end
      if (bus.done)  ndone++;
      if (bus.error) nerr++;
      if (run && (bus.done || bus.error)) begin
        lat = t; lrd = nrd; lwr = nwr; run = 0;
      end
      if (bus.start && !bus.busy) begin
        t = 0; run = 1; nrd = 0; nwr = 0;
      end
    end
  end

  task automatic chk(input string nm, input int got,
                     input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  function automatic step_t nz(input logic [16:0] e);
    step_t s;
    s.start = 1'($urandom);
    s.opc   = 5'($urandom);
    s.mr    = 1'($urandom);
    s.exp   = e;
    return s;
  endfunction

  // expected trace of one transaction, built from the op rules
  task automatic add_txn(input logic [4:0] opc, input int w,
                         input bit tmo, input int gap,
                         input bit pulse_t4);
    step_t s;
    int n;
    for (int i = 0; i < gap - 1; i++) begin
      s = nz(17'h0);
      s.start = 1'b0;
      scr.push_back(s);
    end
    s = nz(17'h0);
    s.start = 1'b1;
    s.opc = opc;
    scr.push_back(s);
    if (opc != OP_LD && opc != OP_LDI && opc != OP_ST) begin
      scr.push_back(nz(ERR | BUSY));
      return;
    end
    scr.push_back(nz(GRB | BAOUT | ROUT | YIN | BUSY));
    s = nz(COUT | ADD | ZIN | BUSY);
    if (pulse_t4) s.start = 1'b1;
    scr.push_back(s);
    if (opc == OP_LDI) begin
      scr.push_back(nz(ZLO | GRA | RIN | BUSY));
      scr.push_back(nz(DONE | BUSY));
      return;
    end
    scr.push_back(nz(ZLO | MARIN | BUSY));
    if (opc == OP_ST) scr.push_back(nz(GRA | ROUT | MDRIN | BUSY));
    n = tmo ? T : w + 1;
    for (int k = 0; k < n; k++) begin
      s = nz(opc == OP_LD ? (READ | MDRIN | BUSY) : (WRITE | BUSY));
      s.mr = !tmo && (k == w);
      scr.push_back(s);
    end
    if (tmo) begin
      scr.push_back(nz(ERR | BUSY));
    end else begin
      if (opc == OP_LD) scr.push_back(nz(GRA | RIN | BUSY));
      scr.push_back(nz(DONE | BUSY));
    end
  endtask

  task automatic play();
    step_t s;
    while (scr.size() > 0) begin
      s = scr.pop_front();
      bus.start     = s.start;
      bus.opcode    = s.opc;
      bus.mem_ready = s.mr;
      exp_vec       = s.exp;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, w, d0;
    bit tmo;
    logic [4:0] opc;
    clr = 1'b1;
    bus.start = 1'b1;
    bus.opcode = OP_LDI;
    bus.mem_ready = 1'b1;
    exp_vec = 17'h0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_outs", int'(dv), 0);
    @(posedge clk);
    #1;
    clr = 1'b0;

    add_txn(OP_LDI, 0, 0, 1, 0);
    play();
    chk("ldi_lat", lat, 4);
    chk("ldi_done", ndone, 1);

    add_txn(OP_LD, 3, 0, 2, 0);
    play();
    chk("ld_lat", lat, 9);
    chk("ld_reads", lrd, 4);

    add_txn(OP_ST, 0, 1, 1, 0);
    play();
    chk("st_tmo_lat", lat, 20);
    chk("st_tmo_writes", lwr, 15);
    chk("st_tmo_err", nerr, 1);
    chk("st_tmo_nodone", ndone, 2);

    add_txn(5'b00111, 0, 0, 1, 0);
    play();
    chk("illegal_lat", lat, 1);
    chk("illegal_err", nerr, 2);

    add_txn(OP_ST, T - 1, 0, 1, 0);
    play();
    chk("st_edge_lat", lat, 20);
    chk("st_edge_noerr", nerr, 2);

    d0 = ndone;
    add_txn(OP_LD, 1, 0, 1, 1);
    add_txn(OP_LDI, 0, 0, 1, 0);
    play();
    chk("b2b_dones", ndone - d0, 2);
    chk("b2b_lat", lat, 4);

    add_txn(OP_ST, 5, 0, 1, 0);
    while (scr.size() > 6) void'(scr.pop_back());
    play();
    #2;
    chk("clr_pre_write", int'(bus.Write), 1);
    clr = 1'b1;
    bus.start = 1'b0;
    exp_vec = 17'h0;
    #1;
    chk("clr_write", int'(bus.Write), 0);
    chk("clr_busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    add_txn(OP_LD, 2, 0, 1, 0);
    play();
    chk("post_clr_lat", lat, 8);
    chk("post_clr_reads", lrd, 3);

    for (int i = 0; i < 60; i++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0:       opc = OP_LD;
        1:       opc = OP_LDI;
        2:       opc = OP_ST;
        default: opc = 5'($urandom_range(3, 31));
      endcase
      r = int'($urandom_range(0, 7));
      tmo = (r == 0);
      w = (r == 1) ? T - 1 : int'($urandom_range(0, 4));
      add_txn(opc, w, tmo, int'($urandom_range(1, 3)),
              1'($urandom));
    end
    play();
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
